// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: joystick-to-core conditioner with autofire, fixed-length coin pulse and DIP capture
module arcade_input_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int BTN_W = 10,
  parameter int COIN_BIT = 8,
  parameter int COIN_CYCLES = 200000,
  parameter int AF_DIV = 20000,
  parameter int DIP_BANKS = 8,
  parameter logic [7:0] DIP_INDEX = 8'd254
) (
  input  logic                           clk_sys,
  input  logic                           reset,
  input  logic [NUM_PLAYERS*BTN_W-1:0]   joy_in,
  input  logic [BTN_W-1:0]               af_mask,
  input  logic [3:0]                     af_rate,
  input  logic                           ioctl_download,
  input  logic                           ioctl_wr,
  input  logic [7:0]                     ioctl_index,
  input  logic [24:0]                    ioctl_addr,
  input  logic [7:0]                     ioctl_dout,
  output logic [NUM_PLAYERS*BTN_W-1:0]   ctrl_n,
  output logic [DIP_BANKS*8-1:0]         dip_out
);
  localparam int CW = $clog2(COIN_CYCLES + 1);
  localparam int PW = AF_DIV > 1 ? $clog2(AF_DIV) : 1;
  localparam int AW = DIP_BANKS > 1 ? $clog2(DIP_BANKS) : 1;
  logic [NUM_PLAYERS*BTN_W-1:0] s1;
  logic [PW-1:0] pre;
  logic tick;
  logic [BTN_W-1:0] mask_eff;
  logic [DIP_BANKS*8-1:0] dip_q = '0;
  assign tick = pre == PW'(AF_DIV - 1);
  assign mask_eff = af_mask & ~(BTN_W'(1) << COIN_BIT);
  assign dip_out = dip_q;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1 <= '0;
      pre <= '0;
    end else begin
      s1 <= joy_in;
      pre <= tick ? '0 : pre + 1'b1;
    end
  end
  always_ff @(posedge clk_sys)
    if (ioctl_wr && ioctl_index == DIP_INDEX && ioctl_addr < 25'(DIP_BANKS))
      dip_q[{ioctl_addr[AW-1:0], 3'b000} +: 8] <= ioctl_dout;
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_p
    logic [BTN_W-1:0] btn, act, ctrl_q;
    logic [3:0] af_cnt;
    logic [CW-1:0] coin_cnt;
    logic af_phase, coin_prev, held, coin_rise;
    assign btn = s1[p*BTN_W +: BTN_W];
    assign held = |(btn & mask_eff) && af_rate != 4'd0;
    assign coin_rise = btn[COIN_BIT] && !coin_prev && coin_cnt == '0 && !ioctl_download;
    always_comb begin
      act = btn & (af_rate != 4'd0 ? ~mask_eff | {BTN_W{af_phase}} : '1);
      act[COIN_BIT] = coin_rise || coin_cnt > CW'(1);
    end
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        ctrl_q <= '1;
        af_cnt <= '0;
        af_phase <= 1'b1;
        coin_cnt <= '0;
        coin_prev <= 1'b0;
      end else begin
        coin_prev <= btn[COIN_BIT];
        if (ioctl_download) begin
          ctrl_q <= '1;
          af_cnt <= '0;
          af_phase <= 1'b1;
          coin_cnt <= '0;
        end else begin
          ctrl_q <= ~act;
          coin_cnt <= coin_rise ? CW'(COIN_CYCLES) : coin_cnt != '0 ? coin_cnt - 1'b1 : '0;
          if (!held) begin
            af_cnt <= '0;
            af_phase <= 1'b1;
          end else if (tick) begin
            af_cnt <= af_cnt == af_rate - 4'd1 ? 4'd0 : af_cnt + 4'd1;
            af_phase <= af_cnt == af_rate - 4'd1 ? ~af_phase : af_phase;
          end
        end
      end
    end
    assign ctrl_n[p*BTN_W +: BTN_W] = ctrl_q;
  end
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// tb_arcade_input_ctrl: directed checks of reset, passthrough, autofire, coin, DIP capture and download gate
module tb_arcade_input_ctrl;
  logic clk_sys = 0, reset = 1, ioctl_download = 0, ioctl_wr = 0;
  logic [19:0] joy_in = '1, ctrl_n;
  logic [9:0] af_mask = '0;
  logic [3:0] af_rate = '0;
  logic [7:0] ioctl_index = '0, ioctl_dout = '0;
  logic [24:0] ioctl_addr = '0;
  logic [63:0] dip_out;
  int n_chk = 0, n_fail = 0;
  arcade_input_ctrl #(.NUM_PLAYERS(2), .BTN_W(10), .COIN_BIT(8), .COIN_CYCLES(5), .AF_DIV(4),
    .DIP_BANKS(8), .DIP_INDEX(8'd254)) dut (
    .clk_sys(clk_sys), .reset(reset), .joy_in(joy_in), .af_mask(af_mask), .af_rate(af_rate),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ctrl_n(ctrl_n), .dip_out(dip_out));
  always #5 clk_sys = ~clk_sys;
  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    logic smp [40];
    int runs [8];
    int nr, len, lows, first, last;
    repeat (3) cyc();
    check("rst_hold", ctrl_n, 20'hFFFFF);
    reset = 0;
    cyc();
    check("rst_p1", ctrl_n, 20'hFFFFF);
    cyc();
    check("rst_p2", ctrl_n, 20'h00000);
    joy_in = '0;
    repeat (10) cyc();
    check("idle", ctrl_n, 20'hFFFFF);
    joy_in[10] = 1;
    cyc();
    check("pass_n1", ctrl_n[10], 1'b1);
    joy_in[10] = 0;
    cyc();
    check("pass_n2", ctrl_n[10], 1'b0);
    cyc();
    check("pass_n3", ctrl_n[10], 1'b1);
    af_rate = 2;
    af_mask = 10'h010;
    joy_in[4] = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      smp[i] = ctrl_n[4];
    end
    check("af_n1", smp[0], 1'b1);
    check("af_n2", smp[1], 1'b0);
    nr = 0;
    len = 1;
    for (int i = 2; i < 40; i++)
      if (smp[i] == smp[i-1]) len++;
      else begin
        if (nr < 8) runs[nr] = len;
        nr++;
        len = 1;
      end
    check("af_nruns", nr >= 4, 1'b1);
    check("af_first_low", runs[0] >= 5 && runs[0] <= 8, 1'b1);
    check("af_high1", runs[1], 8);
    check("af_low2", runs[2], 8);
    check("af_high2", runs[3], 8);
    joy_in[4] = 0;
    cyc();
    cyc();
    check("af_release", ctrl_n[4], 1'b1);
    repeat (3) cyc();
    joy_in[4] = 1;
    cyc();
    cyc();
    check("af_repress", ctrl_n[4], 1'b0);
    joy_in = '0;
    af_rate = 0;
    af_mask = '0;
    repeat (4) cyc();
    lows = 0; first = -1; last = -1;
    joy_in[8] = 1;
    for (int i = 1; i <= 22; i++) begin
      cyc();
      if (!ctrl_n[8]) begin
        lows++;
        if (first < 0) first = i;
        last = i;
      end
      if (i == 20) joy_in[8] = 0;
    end
    check("coin_len", lows, 5);
    check("coin_start", first, 2);
    check("coin_end", last, 6);
    repeat (5) cyc();
    lows = 0;
    joy_in[8] = 1;
    for (int i = 1; i <= 22; i++) begin
      cyc();
      if (!ctrl_n[8]) lows++;
      if (i == 2) joy_in[8] = 0;
      if (i == 4) joy_in[8] = 1;
      if (i == 20) joy_in[8] = 0;
    end
    check("coin_noretrig", lows, 5);
    ioctl_wr = 1; ioctl_index = 8'd254; ioctl_addr = 25'd1; ioctl_dout = 8'hA5;
    cyc();
    check("dip_wr", dip_out, 64'h0000_0000_0000_A500);
    ioctl_addr = 25'd9; ioctl_dout = 8'hFF;
    cyc();
    ioctl_index = 8'd0; ioctl_addr = 25'd2; ioctl_dout = 8'h33;
    cyc();
    ioctl_wr = 0;
    cyc();
    check("dip_ignore", dip_out, 64'h0000_0000_0000_A500);
    ioctl_wr = 1; ioctl_index = 8'd254; ioctl_addr = 25'd7; ioctl_dout = 8'h5A;
    cyc();
    ioctl_wr = 0;
    check("dip_last", dip_out, 64'h5A00_0000_0000_A500);
    reset = 1;
    ioctl_wr = 1; ioctl_addr = 25'd0; ioctl_dout = 8'h3C;
    cyc();
    ioctl_wr = 0;
    cyc();
    check("dip_reset", dip_out, 64'h5A00_0000_0000_A53C);
    reset = 0;
    repeat (3) cyc();
    ioctl_download = 1;
    joy_in = 20'h0010F;
    cyc();
    check("dl_gate1", ctrl_n, 20'hFFFFF);
    repeat (3) cyc();
    check("dl_gate2", ctrl_n, 20'hFFFFF);
    ioctl_download = 0;
    cyc();
    check("dl_after", ctrl_n, 20'hFFFF0);
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (!ctrl_n[8]) lows++;
    end
    check("dl_nocoin", lows, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
